// File: rtl/i2c_av_write_engine.sv
// Bit-level I2C 3-byte write master (START, 3x(8 bits + ACK), STOP) on a quarter-bit tick.
// Optional SCL clock stretching in BIT/ACK/STOP Q1 when I2C_CLK_STRETCH_EN is defined.
module i2c_av_write_engine #(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 20000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [23:0] iDATA,
  input  logic        iGO,
  output logic        oBUSY,
  output logic        oEND,
  output logic        oACK_ERR,
  input  logic        iSCL_SENSE,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT
);

  localparam int          DIV    = CLK_FREQ / (4 * I2C_FREQ);
  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_e;

  state_e      st_q, st_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [23:0] sr_q, sr_d;
  logic        busy_q, busy_d, end_q, end_d, err_q, err_d;
  logic        scl_q, scl_d, sda_low_q, sda_low_d;
  logic        tick, hold;

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low freezes the quarter on its final cycle.
  assign hold = (st_q == S_BIT || st_q == S_ACK || st_q == S_STOP) &&
                (qtr_q == 2'd1) && !iSCL_SENSE;
`else
  logic unused_scl_sense;
  assign unused_scl_sense = iSCL_SENSE;
  assign hold = 1'b0;
`endif

  assign tick = busy_q && (div_q == DIV_M1);

  always_comb begin
    st_d   = st_q;
    qtr_d  = qtr_q;
    div_d  = div_q;
    bit_d  = bit_q;
    byte_d = byte_q;
    sr_d   = sr_q;
    busy_d = busy_q;
    err_d  = err_q;
    end_d  = 1'b0;
    if (!busy_q) begin
      // end_q blocks a request landing in the completion cycle
      if (iGO && !end_q) begin
        sr_d   = iDATA;
        err_d  = 1'b0;
        busy_d = 1'b1;
        div_d  = '0;
        st_d   = S_START;
        qtr_d  = 2'd0;
        bit_d  = 3'd0;
        byte_d = 2'd0;
      end
    end else if (!tick) begin
      div_d = div_q + 16'd1;
    end else if (!hold) begin
      div_d = '0;
      qtr_d = qtr_q + 2'd1;
      if (st_q == S_ACK && qtr_q == 2'd2 && I2C_SDAT) err_d = 1'b1;
      if (qtr_q == 2'd3) begin
        case (st_q)
          S_START: st_d = S_BIT;
          S_BIT: begin
            sr_d  = {sr_q[22:0], 1'b0};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) st_d = S_ACK;
          end
          S_ACK: begin
            if (err_q || byte_q == 2'd2) st_d = S_STOP;
            else begin
              byte_d = byte_q + 2'd1;
              st_d   = S_BIT;
            end
          end
          S_STOP: begin
            st_d   = S_IDLE;
            busy_d = 1'b0;
            end_d  = 1'b1;
          end
          default: st_d = S_IDLE;
        endcase
      end
    end

    // Line levels for the upcoming quarter, registered alongside the state.
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    case (st_d)
      S_START: begin
        scl_d     = (qtr_d < 2'd2);
        sda_low_d = (qtr_d != 2'd0);
      end
      S_BIT: begin
        scl_d     = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        sda_low_d = ~sr_d[23];
      end
      S_ACK: begin
        scl_d     = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        sda_low_d = 1'b0;
      end
      S_STOP: begin
        scl_d     = (qtr_d != 2'd0);
        sda_low_d = (qtr_d < 2'd2);
      end
      default: begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      st_q      <= S_IDLE;
      qtr_q     <= 2'd0;
      div_q     <= '0;
      bit_q     <= 3'd0;
      byte_q    <= 2'd0;
      sr_q      <= '0;
      busy_q    <= 1'b0;
      end_q     <= 1'b0;
      err_q     <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      qtr_q     <= qtr_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      sr_q      <= sr_d;
      busy_q    <= busy_d;
      end_q     <= end_d;
      err_q     <= err_d;
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
    end
  end

  assign oBUSY    = busy_q;
  assign oEND     = end_q;
  assign oACK_ERR = err_q;
  assign I2C_SCLK = scl_q;
  assign I2C_SDAT = sda_low_q ? 1'b0 : 1'bz;

endmodule
